el2_dccm_sram_responder: RTL and testbench
==========================================

// Module: el2_dccm_sram_responder
// PURPOSE
// - Memory-side (sink) end of the DCCM SRAM bank interface: consumes per-bank
//   clken/wren/addr/wr_data/wr_ecc and returns dout/ecc per bank.
// - Serves as the behavioural DCCM array behind the core's SRAM source port in sims/FPGA.
// - Adds a post-reset zero-initialisation sweep and a one-shot ECC error
//   injector so the core's DCCM single/double-error paths can be exercised.
// PARAMETERS
// - NUM_BANKS  4     number of DCCM banks
// - DEPTH      1024  words per bank (power of 2)
// - AW         10    bank address width, = log2(DEPTH)
// - DATA_W     32    data bits per bank word
// - ECC_W      7     ECC bits per bank word
// - INIT_ECC   7'h00 ECC value written with zero data during the init sweep
// PORTS
// - clk             in   1               core clock
// - rst_l           in   1               async reset, active low
// - dccm_clken      in   NUM_BANKS       bank access enable
// - dccm_wren_bank  in   NUM_BANKS       bank write enable (qualified by clken)
// - dccm_addr_bank  in   NUM_BANKS*AW    per-bank word address
// - dccm_wr_data_bank in NUM_BANKS*DATA_W per-bank write data
// - dccm_wr_ecc_bank in  NUM_BANKS*ECC_W  per-bank write ECC
// - dccm_bank_dout  out  NUM_BANKS*DATA_W per-bank read data
// - dccm_bank_ecc   out  NUM_BANKS*ECC_W  per-bank read ECC
// - init_done       out  1               high once zero sweep has completed
// - err_inj_arm     in   1               pulse: arm one-shot injection
// - err_inj_bank    in   2               target bank (log2 NUM_BANKS)
// - err_inj_bit     in   6               bit index 0..DATA_W+ECC_W-1 in {ecc,data}
// - err_inj_double  in   1               1 = flip bit and (bit+1) mod 39
// - err_inj_done    out  1               1-cycle pulse when injection applied
// BEHAVIOUR
// - Reset: dout/ecc = 0, init_done = 0, err_inj_done = 0, injector disarmed, FSM = INIT, ptr = 0.
// - FSM INIT: each cycle write {INIT_ECC,0} at ptr in all banks, ptr++.
//   After ptr = DEPTH-1 is written, go to READY and set init_done next cycle.
//   Sweep takes DEPTH cycles. Core requests are ignored during INIT; dout/ecc stay 0.
// - READY is terminal. Only rst_l low returns to INIT; a reset mid-sweep restarts at ptr=0.
// - Read: clken[b]=1, wren[b]=0 in cycle N; word at addr[b] appears on dout/ecc[b] in N+1.
//   The value holds until the next read of bank b. Banks are fully independent.
// - Write: clken[b]=1, wren[b]=1; array updated at the clock edge. dout/ecc[b] unchanged (no write-through).
// - wren[b]=1 with clken[b]=0: no effect.
// - A read in the cycle after a write to the same address returns the new data.
// - Injector: err_inj_arm latches bank/bit/double and sets armed.
//   - Next READY read of err_inj_bank: the registered {ecc,data} is XORed with the mask.
//   - Mask = 1<<bit, or additionally 1<<((bit+1)%39) if double.
//   - That read clears armed; err_inj_done pulses in the same cycle the corrupted data is presented.
//   - Array contents are never modified.
//   - arm while already armed: new fields overwrite and stay armed.
//   - arm coincident with the target read: that read is not corrupted; the next one is.
//   - bit >= 39: treated as no-op mask, armed still clears, done still pulses.
// - Reset clears armed.
// TESTING
// - Reset then count cycles -> init_done rises exactly DEPTH+1 cycles after rst_l high; all reads return 0/INIT_ECC.
// - Write bank1 addr 0x3FF data 0xDEADBEEF ecc 0x55, read next cycle -> dout[1]=0xDEADBEEF, ecc[1]=0x55 one cycle later.
// - Simultaneous reads of banks 0..3 at distinct addresses -> all four outputs update in the same cycle; an idle bank holds its last value.
// - Arm bank2 bit 5 single; read word 0x12345678 -> dout 0x12345658, done pulse; reread -> 0x12345678, no pulse.
// - Arm bank0 bit 38 double; read data 0 ecc 0 -> ecc=7'h40, data=0x00000001.
// - Assert rst_l low at ptr=500 during INIT -> outputs 0, sweep restarts at 0, init_done after DEPTH+1 cycles.

Source files
------------

// File: rtl/el2_dccm_sram_responder_if.sv
`default_nettype none
// ============================================================================
// el2_dccm_sram_responder_if : per-bank DCCM SRAM request/response bundle
// Revision: 1.0
// ============================================================================
interface el2_dccm_sram_responder_if #(
  parameter int NUM_BANKS = 4,
  parameter int AW        = 10,
  parameter int DATA_W    = 32,
  parameter int ECC_W     = 7
);
  logic [NUM_BANKS-1:0]        dccm_clken;
  logic [NUM_BANKS-1:0]        dccm_wren_bank;
  logic [NUM_BANKS*AW-1:0]     dccm_addr_bank;
  logic [NUM_BANKS*DATA_W-1:0] dccm_wr_data_bank;
  logic [NUM_BANKS*ECC_W-1:0]  dccm_wr_ecc_bank;
  logic [NUM_BANKS*DATA_W-1:0] dccm_bank_dout;
  logic [NUM_BANKS*ECC_W-1:0]  dccm_bank_ecc;

  modport master (
    output dccm_clken, dccm_wren_bank, dccm_addr_bank,
           dccm_wr_data_bank, dccm_wr_ecc_bank,
    input  dccm_bank_dout, dccm_bank_ecc
  );

  modport slave (
    input  dccm_clken, dccm_wren_bank, dccm_addr_bank,
           dccm_wr_data_bank, dccm_wr_ecc_bank,
    output dccm_bank_dout, dccm_bank_ecc
  );
endinterface
`default_nettype wire

// File: rtl/el2_dccm_sram_responder.sv
`default_nettype none
// ============================================================================
// el2_dccm_sram_responder : behavioural DCCM bank array with zero-init sweep
//                           and one-shot read-path ECC error injector
// Revision: 1.0
// ============================================================================
module el2_dccm_sram_responder #(
  parameter int                 NUM_BANKS = 4,
  parameter int                 DEPTH     = 1024,
  parameter int                 AW        = 10,
  parameter int                 DATA_W    = 32,
  parameter int                 ECC_W     = 7,
  parameter logic [ECC_W-1:0]   INIT_ECC  = 7'h00,
  parameter int                 BANK_W    = 2,
  parameter int                 BIT_W     = 6
) (
  input  wire                   clk,
  input  wire                   rst_l,
  el2_dccm_sram_responder_if.slave bus,
  output logic                  o_init_done,
  input  wire                   i_err_inj_arm,
  input  wire  [BANK_W-1:0]     i_err_inj_bank,
  input  wire  [BIT_W-1:0]      i_err_inj_bit,
  input  wire                   i_err_inj_double,
  output logic                  o_err_inj_done
);

  localparam int            c_WW       = DATA_W + ECC_W;
  localparam logic [AW-1:0] c_PTR_LAST = AW'(DEPTH - 1);
  localparam logic [0:0]    c_ST_INIT  = 1'b0;
  localparam logic [0:0]    c_ST_READY = 1'b1;

  logic [0:0]           r_state;
  logic [AW-1:0]        r_ptr;
  logic                 r_init_done;
  logic                 r_armed;
  logic [BANK_W-1:0]    r_inj_bank;
  logic [BIT_W-1:0]     r_inj_bit;
  logic                 r_inj_double;
  logic                 r_inj_done;

  logic [NUM_BANKS-1:0] w_rd_en;
  logic [NUM_BANKS-1:0] w_wr_en;
  logic [NUM_BANKS-1:0] w_hit;
  logic [c_WW-1:0]      w_mask;
  logic [BIT_W-1:0]     w_bit2;
  logic [c_WW-1:0]      w_rd [NUM_BANKS];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= c_ST_INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= (r_state == c_ST_READY);
      if (r_state == c_ST_INIT) begin
        r_ptr <= r_ptr + AW'(1);
        if (r_ptr == c_PTR_LAST) begin
          r_state <= c_ST_READY;
        end
      end
    end
  end

  // An arm in the same cycle as the target read defers corruption to the next read.
  always_comb begin
    w_rd_en = '0;
    w_wr_en = '0;
    w_hit   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_rd_en[i] = (r_state == c_ST_READY) && bus.dccm_clken[i] && !bus.dccm_wren_bank[i];
      w_wr_en[i] = (r_state == c_ST_READY) && bus.dccm_clken[i] && bus.dccm_wren_bank[i];
      w_hit[i]   = w_rd_en[i] && r_armed && !i_err_inj_arm && (r_inj_bank == BANK_W'(i));
    end
  end

  always_comb begin
    w_mask = '0;
    w_bit2 = (r_inj_bit == BIT_W'(c_WW - 1)) ? '0 : (r_inj_bit + BIT_W'(1));
    if (r_inj_bit < BIT_W'(c_WW)) begin
      w_mask[r_inj_bit] = 1'b1;
      if (r_inj_double) begin
        w_mask[w_bit2] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_armed      <= 1'b0;
      r_inj_bank   <= '0;
      r_inj_bit    <= '0;
      r_inj_double <= 1'b0;
      r_inj_done   <= 1'b0;
    end else begin
      r_inj_done <= |w_hit;
      if (i_err_inj_arm) begin
        r_armed      <= 1'b1;
        r_inj_bank   <= i_err_inj_bank;
        r_inj_bit    <= i_err_inj_bit;
        r_inj_double <= i_err_inj_double;
      end else if (|w_hit) begin
        r_armed <= 1'b0;
      end
    end
  end

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [c_WW-1:0] r_mem [DEPTH];
      logic [c_WW-1:0] r_rd;
      logic [AW-1:0]   w_addr;

      assign w_addr = bus.dccm_addr_bank[b*AW +: AW];

      always_ff @(posedge clk) begin
        if (r_state == c_ST_INIT) begin
          r_mem[r_ptr] <= {INIT_ECC, {DATA_W{1'b0}}};
        end else if (w_wr_en[b]) begin
          r_mem[w_addr] <= {bus.dccm_wr_ecc_bank[b*ECC_W +: ECC_W],
                            bus.dccm_wr_data_bank[b*DATA_W +: DATA_W]};
        end
      end

      // Corruption lives only in the output register; the array stays clean.
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          r_rd <= '0;
        end else if (w_rd_en[b]) begin
          r_rd <= r_mem[w_addr] ^ (w_hit[b] ? w_mask : {c_WW{1'b0}});
        end
      end

      assign w_rd[b] = r_rd;
    end
  endgenerate

  always_comb begin
    bus.dccm_bank_dout = '0;
    bus.dccm_bank_ecc  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bus.dccm_bank_dout[i*DATA_W +: DATA_W] = w_rd[i][DATA_W-1:0];
      bus.dccm_bank_ecc[i*ECC_W +: ECC_W]    = w_rd[i][c_WW-1:DATA_W];
    end
  end

  assign o_init_done    = r_init_done;
  assign o_err_inj_done = r_inj_done;

endmodule
`default_nettype wire

// File: tb/tb_el2_dccm_sram_responder.sv
`default_nettype none
// ============================================================================
// tb_el2_dccm_sram_responder : directed stimulus with queued expectations
// Revision: 1.0
// ============================================================================
module tb_el2_dccm_sram_responder;

  localparam int c_DEPTH = 1024;

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0][6:0]  e;
    logic             done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       init_done;
  logic       arm;
  logic [1:0] arm_bank;
  logic [5:0] arm_bit;
  logic       arm_dbl;
  logic       inj_done;

  exp_t             q[$];
  logic [3:0][31:0] last_d;
  logic [3:0][6:0]  last_e;
  logic             drv_act = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;
  int               n_cyc;

  always #5 clk = ~clk;

  el2_dccm_sram_responder_if #(.NUM_BANKS(4), .AW(10), .DATA_W(32), .ECC_W(7)) bus ();

  el2_dccm_sram_responder dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .bus              (bus),
    .o_init_done      (init_done),
    .i_err_inj_arm    (arm),
    .i_err_inj_bank   (arm_bank),
    .i_err_inj_bit    (arm_bit),
    .i_err_inj_double (arm_dbl),
    .o_err_inj_done   (inj_done)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every driven cycle has one queued expectation covering all four banks.
  always @(posedge clk) begin : monitor
    logic act;
    exp_t x;
    act = drv_act;
    #1;
    if (act) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        x = q.pop_front();
        chk("dout", bus.dccm_bank_dout, x.d);
        chk("ecc", bus.dccm_bank_ecc, x.e);
        chk("inj_done", inj_done, x.done);
      end
    end
  end

  task automatic clear_bus();
    bus.dccm_clken        = '0;
    bus.dccm_wren_bank    = '0;
    bus.dccm_addr_bank    = '0;
    bus.dccm_wr_data_bank = '0;
    bus.dccm_wr_ecc_bank  = '0;
    arm = 1'b0; arm_bank = '0; arm_bit = '0; arm_dbl = 1'b0;
  endtask

  task automatic begin_cyc();
    @(negedge clk);
    clear_bus();
    drv_act = 1'b1;
  endtask

  task automatic push(input logic done);
    exp_t x;
    x.d = last_d; x.e = last_e; x.done = done;
    q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    clear_bus();
    drv_act = 1'b0;
  endtask

  task automatic set_wr(input int b, input logic [9:0] a, input logic [31:0] d, input logic [6:0] e);
    bus.dccm_clken[b]                = 1'b1;
    bus.dccm_wren_bank[b]            = 1'b1;
    bus.dccm_addr_bank[b*10 +: 10]   = a;
    bus.dccm_wr_data_bank[b*32 +: 32] = d;
    bus.dccm_wr_ecc_bank[b*7 +: 7]   = e;
  endtask

  task automatic set_rd(input int b, input logic [9:0] a, input logic [31:0] ed, input logic [6:0] ee);
    bus.dccm_clken[b]              = 1'b1;
    bus.dccm_addr_bank[b*10 +: 10] = a;
    last_d[b] = ed;
    last_e[b] = ee;
  endtask

  task automatic wr1(input int b, input logic [9:0] a, input logic [31:0] d, input logic [6:0] e);
    begin_cyc();
    set_wr(b, a, d, e);
    push(1'b0);
  endtask

  task automatic rd1(input int b, input logic [9:0] a, input logic [31:0] ed,
                     input logic [6:0] ee, input logic edone);
    begin_cyc();
    set_rd(b, a, ed, ee);
    push(edone);
  endtask

  task automatic arm1(input logic [1:0] b, input logic [5:0] bt, input logic dbl);
    begin_cyc();
    arm = 1'b1; arm_bank = b; arm_bit = bt; arm_dbl = dbl;
    push(1'b0);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (init_done) break;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, bus.dccm_bank_dout, '0);
    chk({tag, "_ecc"}, bus.dccm_bank_ecc, '0);
    chk({tag, "_init_done"}, init_done, 1'b0);
    chk({tag, "_inj_done"}, inj_done, 1'b0);
  endtask

  initial begin
    rst_l  = 1'b0;
    clear_bus();
    last_d = '0;
    last_e = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_l = 1'b1;

    // Requests issued during the sweep must be ignored.
    fork
      begin
        wait_init(n_cyc);
        chk("init_cycles", n_cyc, c_DEPTH + 1);
      end
      begin
        wr1(0, 10'h000, 32'hA5A5A5A5, 7'h7F);
        rd1(0, 10'h005, 32'h0, 7'h00, 1'b0);
        idle();
      end
    join

    rd1(0, 10'h000, 32'h0, 7'h00, 1'b0);
    rd1(3, 10'h3FF, 32'h0, 7'h00, 1'b0);

    wr1(1, 10'h3FF, 32'hDEADBEEF, 7'h55);
    rd1(1, 10'h3FF, 32'hDEADBEEF, 7'h55, 1'b0);

    begin_cyc();
    set_wr(0, 10'h001, 32'h11111111, 7'h01);
    set_wr(1, 10'h002, 32'h22222222, 7'h02);
    set_wr(2, 10'h004, 32'h33333333, 7'h03);
    set_wr(3, 10'h008, 32'h44444444, 7'h04);
    push(1'b0);
    begin_cyc();
    set_rd(0, 10'h001, 32'h11111111, 7'h01);
    set_rd(1, 10'h002, 32'h22222222, 7'h02);
    set_rd(2, 10'h004, 32'h33333333, 7'h03);
    set_rd(3, 10'h008, 32'h44444444, 7'h04);
    push(1'b0);
    wr1(2, 10'h100, 32'hCAFEF00D, 7'h7F);
    rd1(2, 10'h100, 32'hCAFEF00D, 7'h7F, 1'b0);

    // wren without clken must leave the array untouched.
    begin_cyc();
    bus.dccm_wren_bank[0]        = 1'b1;
    bus.dccm_addr_bank[9:0]      = 10'h010;
    bus.dccm_wr_data_bank[31:0]  = 32'hFFFFFFFF;
    bus.dccm_wr_ecc_bank[6:0]    = 7'h7F;
    push(1'b0);
    rd1(0, 10'h010, 32'h0, 7'h00, 1'b0);

    wr1(2, 10'h020, 32'h12345678, 7'h0A);
    arm1(2'd2, 6'd5, 1'b0);
    rd1(1, 10'h3FF, 32'hDEADBEEF, 7'h55, 1'b0);
    rd1(2, 10'h020, 32'h12345658, 7'h0A, 1'b1);
    rd1(2, 10'h020, 32'h12345678, 7'h0A, 1'b0);

    arm1(2'd0, 6'd38, 1'b1);
    rd1(0, 10'h030, 32'h00000001, 7'h40, 1'b1);

    arm1(2'd3, 6'd31, 1'b1);
    rd1(3, 10'h008, 32'hC4444444, 7'h05, 1'b1);

    begin_cyc();
    set_rd(3, 10'h008, 32'h44444444, 7'h04);
    arm = 1'b1; arm_bank = 2'd3; arm_bit = 6'd0; arm_dbl = 1'b0;
    push(1'b0);
    rd1(3, 10'h008, 32'h44444445, 7'h04, 1'b1);

    arm1(2'd1, 6'd45, 1'b0);
    rd1(1, 10'h3FF, 32'hDEADBEEF, 7'h55, 1'b1);
    rd1(1, 10'h3FF, 32'hDEADBEEF, 7'h55, 1'b0);

    arm1(2'd0, 6'd1, 1'b0);
    arm1(2'd1, 6'd2, 1'b0);
    rd1(0, 10'h001, 32'h11111111, 7'h01, 1'b0);
    rd1(1, 10'h3FF, 32'hDEADBEEB, 7'h55, 1'b1);

    idle();
    repeat (3) @(negedge clk);
    chk("sb_drain", q.size(), 0);

    // Reset in the middle of a sweep must restart it from the beginning.
    rst_l = 1'b0;
    @(negedge clk);
    rst_l  = 1'b1;
    last_d = '0;
    last_e = '0;
    repeat (500) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk_reset_outputs("midsweep");
    @(negedge clk);
    rst_l = 1'b1;
    wait_init(n_cyc);
    chk("reinit_cycles", n_cyc, c_DEPTH + 1);

    rd1(1, 10'h3FF, 32'h0, 7'h00, 1'b0);
    rd1(2, 10'h020, 32'h0, 7'h00, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drain_end", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
